// File: rtl/goldschmidt_divider_gen.sv
// Parametrised fixed-latency Goldschmidt integer divider with signed/unsigned mode,
// exact remainder via one final correction step, and divide-by-zero/overflow flags.
module goldschmidt_divider_gen #(
  parameter int WIDTH = 32,
  parameter int ITERS = 5,
  parameter int FRAC  = WIDTH + 4,
  parameter int CW    = $clog2(ITERS + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic [CW-1:0]    count,
  output logic             dz,
  output logic             ovf
);

  localparam int XW = WIDTH + 1 + FRAC;   // x holds up to the full integer quotient
  localparam int YW = FRAC + 2;
  localparam int LW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(FRAC + 1);
  localparam int RW = 2 * WIDTH + 3;
  localparam logic [YW-1:0]    TWO  = YW'(1) << (FRAC + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  if (2 ** ITERS < WIDTH + 1) begin : g_iters_check
    $error("goldschmidt_divider_gen: ITERS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, NORM, ITER, CORR} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] ra, rb, mag_a, mag_b;
  logic             rs, sa, sb;
  logic [XW-1:0]    x, x0, x_nx;
  logic [YW-1:0]    y, y0, y_nx, f;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [LW-1:0]    lz;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   qe;
  logic [RW-1:0]    prod, rr;
  logic [WIDTH-1:0] qm, rm, q_fin, r_fin;
  logic             dz_fin, ovf_fin;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = NORM;
      NORM:    state_nx = ITER;
      ITER:    if (count == CW'(ITERS - 1)) state_nx = CORR;
      CORR:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Normalisation: |b| shifted into [0.5,1), |a| scaled by the same power of two.
  always_comb begin
    abs_a = (rs && ra[WIDTH-1]) ? -ra : ra;
    abs_b = (rs && rb[WIDTH-1]) ? -rb : rb;
    lz = LW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++)
      if (abs_b[i]) lz = LW'(WIDTH - 1 - i);
    sh = SW'(lz) + SW'(FRAC - WIDTH);
    x0 = XW'(abs_a) << sh;
    y0 = YW'(abs_b) << sh;
  end

  always_comb begin
    f    = TWO - y;
    x_nx = XW'(({YW'(0), x} * {XW'(0), f}) >> FRAC);
    y_nx = YW'(({YW'(0), y} * {YW'(0), f}) >> FRAC);
  end

  // Correction: the truncated estimate is within one of the true quotient.
  always_comb begin
    qe   = (WIDTH + 1)'(x >> FRAC);
    prod = RW'(qe) * RW'(mag_b);
    rr   = RW'(mag_a) - prod;
    if (rr[RW-1]) begin
      qm = WIDTH'(qe - (WIDTH + 1)'(1));
      rm = WIDTH'(rr + RW'(mag_b));
    end else if (rr >= RW'(mag_b)) begin
      qm = WIDTH'(qe + (WIDTH + 1)'(1));
      rm = WIDTH'(rr - RW'(mag_b));
    end else begin
      qm = WIDTH'(qe);
      rm = WIDTH'(rr);
    end
    dz_fin  = (rb == '0);
    ovf_fin = rs && (ra == MINV) && (rb == '1);
    if (dz_fin) begin
      q_fin = '1;
      r_fin = ra;
    end else if (ovf_fin) begin
      q_fin = MINV;
      r_fin = '0;
    end else begin
      q_fin = (rs && (sa ^ sb)) ? -qm : qm;
      r_fin = (rs && sa) ? -rm : rm;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= '0; r <= '0; ready <= 1'b0; dz <= 1'b0; ovf <= 1'b0; count <= '0;
      ra <= '0; rb <= '0; rs <= 1'b0; mag_a <= '0; mag_b <= '0;
      sa <= 1'b0; sb <= 1'b0; x <= '0; y <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra <= a; rb <= b; rs <= sgn; count <= '0;
        end
        NORM: begin
          mag_a <= abs_a; mag_b <= abs_b;
          sa <= rs && ra[WIDTH-1]; sb <= rs && rb[WIDTH-1];
          x <= x0; y <= y0;
        end
        ITER: begin
          x <= x_nx; y <= y_nx; count <= count + CW'(1);
        end
        CORR: begin
          q <= q_fin; r <= r_fin; dz <= dz_fin; ovf <= ovf_fin; ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_divider_gen.sv
// Scoreboard bench for goldschmidt_divider_gen: accepted starts push plain-arithmetic
// expected results; an independent monitor checks every ready pulse against them.
module tb_goldschmidt_divider_gen;
  localparam int W = 32;
  localparam int IT = 5;
  localparam int CWT = $clog2(IT + 1);
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic clk = 1'b0, clrn = 1'b0, sgn = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, q, r;
  logic busy, ready, dz, ovf;
  logic [CWT-1:0] count;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int unsigned  t0;
  } exp_t;

  exp_t sbq[$];
  int unsigned cyc = 0;
  int n_chk = 0, n_fail = 0;

  goldschmidt_divider_gen #(.WIDTH(W), .ITERS(IT)) dut (
    .clk(clk), .clrn(clrn), .a(a), .b(b), .sgn(sgn), .start(start),
    .q(q), .r(r), .busy(busy), .ready(ready), .count(count), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic is, input int unsigned t);
    exp_t e;
    longint na, nb;
    e.t0 = t; e.dz = 1'b0; e.ovf = 1'b0;
    if (ib == 0) begin
      e.dz = 1'b1; e.q = '1; e.r = ia;
    end else if (!is) begin
      e.q = ia / ib; e.r = ia % ib;
    end else if (ia == MINV && ib == '1) begin
      e.ovf = 1'b1; e.q = MINV; e.r = '0;
    end else begin
      na = longint'($signed(ia));
      nb = longint'($signed(ib));
      e.q = W'(na / nb);
      e.r = W'(na % nb);
    end
    return e;
  endfunction

  // Acceptance model: start is taken on any edge where the unit is idle.
  always @(posedge clk) begin
    cyc++;
    if (clrn && start && !busy) sbq.push_back(model(a, b, sgn, cyc));
  end

  always @(negedge clk) begin
    if (clrn && ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 64'(ready), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("q", 64'(q), 64'(e.q));
        chk("r", 64'(r), 64'(e.r));
        chk("dz", 64'(dz), 64'(e.dz));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("latency", 64'(cyc - e.t0), 64'(IT + 2));
        chk("count", 64'(count), 64'(IT));
        chk("busy_at_ready", 64'(busy), 64'(0));
      end
    end
  end

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("wait_idle_timeout", 64'(n), 64'(0));
    a = ia; b = ib; sgn = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sgn = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 64'(sbq.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("rst_q", 64'(q), 64'(0));
    chk("rst_r", 64'(r), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_flags", 64'({dz, ovf}), 64'(0));
    clrn = 1'b1;

    op(32'd121, 32'd17, 1'b0);
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
    drain();
    op(32'hFFFF_FF87, 32'd17, 1'b1);
    op(32'd121, 32'hFFFF_FFEF, 1'b1);
    op(32'd5, 32'd0, 1'b0);
    op(32'd10, 32'd3, 1'b0);
    op(MINV, 32'hFFFF_FFFF, 1'b1);
    op(MINV, 32'hFFFF_FFFF, 1'b0);
    op(32'd0, 32'd7, 1'b1);
    op(32'hFFFF_FFFF, 32'd1, 1'b0);
    op(32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Hold start high with changing operands across a whole operation.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom_range(1, 1000); sgn = $urandom_range(0, 1);
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a = 32'd1000; b = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    sbq.delete();
    chk("midrst_q", 64'(q), 64'(0));
    chk("midrst_r", 64'(r), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_ready", 64'(ready), 64'(0));

    for (int i = 0; i < 1500; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = ($urandom_range(0, 1) != 0) ? '1 : 32'd1;
        2: ra = MINV;
        3: rb = $urandom_range(1, 300);
        4: ra = $urandom_range(0, 50);
        5: begin ra = $urandom_range(0, 65535); rb = $urandom_range(1, 65535); end
        default: ;
      endcase
      op(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 9)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
